alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: LAT, default 1, number of clock cycles the ALU inputs are held stable before its result is sampled (legal 1..15).
REQ-002 Parameter: WIDTH, default 32, operand and result width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req_valid  input  1  operation request present.
REQ-006 Port: req_ready  output  1  block can accept a request.
REQ-007 Port: req_a, req_b  input  WIDTH each  request operands.
REQ-008 Port: req_op  input  1  0 = add, 1 = subtract (ALU aluop encoding).
REQ-009 Port: alu_in1, alu_in2  output  WIDTH each  operands driven to ALU.
REQ-010 Port: alu_aluop  output  1  operation driven to ALU.
REQ-011 Port: alu_out  input  WIDTH  ALU result.
REQ-012 Port: alu_zeroflag  input  1  ALU equality flag (in1 == in2).
REQ-013 Port: rsp_valid  output  1  response present; rsp_ready  input  1  consumer accepts response.
REQ-014 Port: rsp_result  output  WIDTH, rsp_zero  output  1  captured ALU result and flag.
REQ-015 Port: busy  output  1  high in any state other than IDLE; op_count  output  16  completed-response counter.

Function
REQ-016 FSM states SHALL be IDLE, DRIVE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on req_valid&&req_ready, register req_a/req_b/req_op onto alu_in1/alu_in2/alu_aluop, load wait counter with LAT-1, go to DRIVE.
REQ-018 DRIVE: ALU outputs held stable; counter decrements each cycle; in the cycle the counter is 0, capture alu_out into rsp_result and alu_zeroflag into rsp_zero, go to RESP.
REQ-019 Latency: request accepted at edge N, alu_in* valid after edge N, rsp_valid asserted after edge N+LAT.
REQ-020 RESP: rsp_valid=1, rsp_result/rsp_zero stable until rsp_valid&&rsp_ready; on that edge return to IDLE and increment op_count.
REQ-021 op_count SHALL wrap 0xFFFF -> 0x0000 without error.
REQ-022 alu_in1/alu_in2/alu_aluop SHALL retain last issued values in IDLE and RESP.
REQ-023 No new request SHALL be accepted in the cycle a response is consumed (req_ready rises one cycle after return to IDLE).
REQ-024 req_a/req_b/req_op changes while not accepted SHALL have no effect.

Reset
REQ-025 While rst=1, state SHALL be IDLE immediately (asynchronous), regardless of clk.
REQ-026 Reset values: req_ready=1 after release, rsp_valid=0, busy=0, alu_in1=0, alu_in2=0, alu_aluop=0, rsp_result=0, rsp_zero=0, op_count=0, wait counter=0.
REQ-027 Reset during DRIVE or RESP SHALL discard the in-flight operation with no response and no op_count change.

Configuration
REQ-028 Macro ALU_ISSUE_SELFCHECK_EN: when defined, add output port rsp_mismatch (1 bit, reset 0).
REQ-029 With macro: at capture compute expected = op ? a-b : a+b (mod 2^WIDTH) and expected_zero = (a==b); rsp_mismatch=1 in RESP iff either differs from captured values; cleared on leaving RESP.
REQ-030 Without macro: no rsp_mismatch port, no comparison logic.

Verification
REQ-031 LAT=1, a=10, b=5, op=0, rsp_ready=1 -> rsp_valid one edge after acceptance, rsp_result=15, rsp_zero=0, op_count=1.
REQ-032 LAT=3, a=10, b=5, op=1 -> alu_in1=10, alu_in2=5, alu_aluop=1 held 3 cycles; rsp_result=5, rsp_zero=0 after edge N+3.
REQ-033 a=5, b=5, op=1, rsp_ready held 0 for 4 cycles -> rsp_valid=1 with rsp_result=0, rsp_zero=1 stable all 4 cycles; req_ready=0 throughout; single op_count increment on release.
REQ-034 a=0xFFFFFFFF, b=1, op=0 -> rsp_result=0x00000000, rsp_zero=0; with ALU_ISSUE_SELFCHECK_EN and ALU model forced to return 0x1 -> rsp_mismatch=1.
REQ-035 LAT=4, assert rst asynchronously mid-DRIVE -> busy=0 and rsp_valid=0 before next clk edge, op_count unchanged, next request completes normally.
REQ-036 Back-to-back requests with req_valid held 1 -> second accepted exactly one cycle after first response handshake; op_count wraps 0xFFFF->0 after 65536 completions.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one add/sub request to an external ALU, holds it LAT cycles, then holds the response until consumed
// Ports: clk, rst (async active-high); req_valid/req_ready/req_a/req_b/req_op request side;
//        alu_in1/alu_in2/alu_aluop to the ALU, alu_out/alu_zeroflag from it;
//        rsp_valid/rsp_ready/rsp_result/rsp_zero response side; busy (not IDLE); op_count (completed responses, wraps).
// Option: define ALU_ISSUE_SELFCHECK_EN to add rsp_mismatch, high in RESP when the captured ALU result or flag is wrong.
module alu_issue_ctrl #(
  parameter int LAT   = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic             alu_aluop,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zeroflag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy,
  output logic [15:0]      op_count
`ifdef ALU_ISSUE_SELFCHECK_EN
  ,
  output logic             rsp_mismatch
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESP} state_t;
  localparam logic [3:0] LOAD = 4'(LAT - 1);
  state_t           r_state, w_next;
  logic [3:0]       r_wait;
  logic [WIDTH-1:0] r_in1, r_in2, r_result;
  logic             r_op, r_zero;
  logic [15:0]      r_op_count;
  logic             w_accept, w_capture, w_consume;
  assign w_accept  = req_valid && r_state == S_IDLE;
  assign w_capture = r_state == S_DRIVE && r_wait == 4'd0;
  assign w_consume = r_state == S_RESP && rsp_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = w_accept ? S_DRIVE : w_capture ? S_RESP : w_consume ? S_IDLE : r_state;
  always_comb begin
    req_ready = r_state == S_IDLE;
    rsp_valid = r_state == S_RESP;
    busy      = r_state != S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_in1      <= '0;
      r_in2      <= '0;
      r_op       <= 1'b0;
      r_wait     <= 4'd0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_op_count <= 16'd0;
    end else begin
      if (w_accept) begin
        r_in1  <= req_a;
        r_in2  <= req_b;
        r_op   <= req_op;
        r_wait <= LOAD;
      end else if (r_state == S_DRIVE && r_wait != 4'd0) r_wait <= r_wait - 4'd1;
      if (w_capture) begin
        r_result <= alu_out;
        r_zero   <= alu_zeroflag;
      end
      if (w_consume) r_op_count <= r_op_count + 16'd1;
    end
  assign alu_in1    = r_in1;
  assign alu_in2    = r_in2;
  assign alu_aluop  = r_op;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign op_count   = r_op_count;
`ifdef ALU_ISSUE_SELFCHECK_EN
  logic             r_mismatch;
  logic [WIDTH-1:0] w_expect;
  assign w_expect = r_op ? r_in1 - r_in2 : r_in1 + r_in2;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_mismatch <= 1'b0;
    else if (w_capture) r_mismatch <= alu_out != w_expect || alu_zeroflag != (r_in1 == r_in2);
    else if (w_consume) r_mismatch <= 1'b0;
  assign rsp_mismatch = r_mismatch;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized self-checking bench running alu_issue_ctrl at LAT=1 and LAT=4 against an arithmetic/timing model
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_op = 1'b0, rsp_ready = 1'b0, bad_alu = 1'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready [2], alu_aluop [2], alu_zero [2], rsp_valid [2], rsp_zero [2], busy [2];
  logic [31:0] alu_in1 [2], alu_in2 [2], alu_out [2], rsp_result [2];
  logic [15:0] op_count [2];
`ifdef ALU_ISSUE_SELFCHECK_EN
  logic        rsp_mismatch [2];
`endif
  int          lat [2] = '{1, 4};
  logic [15:0] cnt [2] = '{16'd0, 16'd0};
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign alu_out[g]  = bad_alu ? 32'd1 : alu_aluop[g] ? alu_in1[g] - alu_in2[g] : alu_in1[g] + alu_in2[g];
    assign alu_zero[g] = alu_in1[g] == alu_in2[g];
  end
  alu_issue_ctrl #(.LAT(1), .WIDTH(32)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_in1(alu_in1[0]), .alu_in2(alu_in2[0]), .alu_aluop(alu_aluop[0]),
    .alu_out(alu_out[0]), .alu_zeroflag(alu_zero[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_result(rsp_result[0]), .rsp_zero(rsp_zero[0]),
    .busy(busy[0]), .op_count(op_count[0])
`ifdef ALU_ISSUE_SELFCHECK_EN
    , .rsp_mismatch(rsp_mismatch[0])
`endif
  );
  alu_issue_ctrl #(.LAT(4), .WIDTH(32)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_in1(alu_in1[1]), .alu_in2(alu_in2[1]), .alu_aluop(alu_aluop[1]),
    .alu_out(alu_out[1]), .alu_zeroflag(alu_zero[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_result(rsp_result[1]), .rsp_zero(rsp_zero[1]),
    .busy(busy[1]), .op_count(op_count[1])
`ifdef ALU_ISSUE_SELFCHECK_EN
    , .rsp_mismatch(rsp_mismatch[1])
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({busy[d], rsp_valid[d]} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_in_progress d%0d: busy,rsp_valid=%b want 00", d, {busy[d], rsp_valid[d]});
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({req_ready[d], rsp_valid[d], busy[d], rsp_zero[d], alu_aluop[d]} !== 5'b10000) begin
        n_fail++;
        $display("FAIL reset_flags d%0d: got %b want 10000", d,
                 {req_ready[d], rsp_valid[d], busy[d], rsp_zero[d], alu_aluop[d]});
      end
      n_chk++;
      if ({alu_in1[d], alu_in2[d], rsp_result[d]} !== 96'd0) begin
        n_fail++;
        $display("FAIL reset_data d%0d: in1=%h in2=%h result=%h want 0", d, alu_in1[d], alu_in2[d], rsp_result[d]);
      end
      n_chk++;
      if (op_count[d] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_op_count d%0d: got %h want 0", d, op_count[d]);
      end
    end
  endtask
  task automatic test_async_reset;
    req_a = 32'd7; req_b = 32'd3; req_op = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (busy[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL inflight_busy d%0d: got %b want 1", d, busy[d]);
      end
    end
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({busy[d], rsp_valid[d], req_ready[d]} !== 3'b001) begin
        n_fail++;
        $display("FAIL async_reset_state d%0d: busy,rsp_valid,req_ready=%b want 001", d,
                 {busy[d], rsp_valid[d], req_ready[d]});
      end
      n_chk++;
      if (op_count[d] !== cnt[d]) begin
        n_fail++;
        $display("FAIL async_reset_count d%0d: got %h want %h", d, op_count[d], cnt[d]);
      end
    end
    @(negedge clk) rst = 1'b0;
    tick;
  endtask
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op, input int stall);
    logic [31:0] e;
    e = op ? a - b : a + b;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1; rsp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    for (int j = 0; j <= 4 + stall; j++) begin
      req_a = $urandom; req_b = $urandom; req_op = 1'($urandom);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if ({busy[d], req_ready[d], rsp_valid[d]} !== {1'b1, 1'b0, j >= lat[d]}) begin
          n_fail++;
          $display("FAIL op_state d%0d cyc%0d: busy,req_ready,rsp_valid=%b want %b", d, j,
                   {busy[d], req_ready[d], rsp_valid[d]}, {1'b1, 1'b0, j >= lat[d]});
        end
        n_chk++;
        if ({alu_in1[d], alu_in2[d], alu_aluop[d]} !== {a, b, op}) begin
          n_fail++;
          $display("FAIL alu_hold d%0d cyc%0d: got %h %h %b want %h %h %b", d, j,
                   alu_in1[d], alu_in2[d], alu_aluop[d], a, b, op);
        end
        if (j >= lat[d]) begin
          n_chk++;
          if ({rsp_result[d], rsp_zero[d]} !== {e, a == b}) begin
            n_fail++;
            $display("FAIL rsp_data d%0d cyc%0d: got %h/%b want %h/%b", d, j, rsp_result[d], rsp_zero[d], e, a == b);
          end
          n_chk++;
          if (op_count[d] !== cnt[d]) begin
            n_fail++;
            $display("FAIL op_count_hold d%0d cyc%0d: got %h want %h", d, j, op_count[d], cnt[d]);
          end
`ifdef ALU_ISSUE_SELFCHECK_EN
          n_chk++;
          if (rsp_mismatch[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch_clean d%0d: got %b want 0", d, rsp_mismatch[d]);
          end
`endif
        end
      end
      if (j < 4 + stall) tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cnt[d] = cnt[d] + 16'd1;
      n_chk++;
      if ({busy[d], req_ready[d], rsp_valid[d]} !== 3'b010) begin
        n_fail++;
        $display("FAIL done_state d%0d: busy,req_ready,rsp_valid=%b want 010", d, {busy[d], req_ready[d], rsp_valid[d]});
      end
      n_chk++;
      if (op_count[d] !== cnt[d]) begin
        n_fail++;
        $display("FAIL op_count_inc d%0d: got %h want %h", d, op_count[d], cnt[d]);
      end
      n_chk++;
      if ({alu_in1[d], alu_in2[d], alu_aluop[d]} !== {a, b, op}) begin
        n_fail++;
        $display("FAIL alu_retain d%0d: got %h %h %b want %h %h %b", d, alu_in1[d], alu_in2[d], alu_aluop[d], a, b, op);
      end
    end
  endtask
  task automatic test_basic;
    do_op(32'd10, 32'd5, 1'b0, 0);
    do_op(32'd10, 32'd5, 1'b1, 0);
  endtask
  task automatic test_stall;
    do_op(32'd5, 32'd5, 1'b1, 4);
  endtask
  task automatic test_overflow;
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
  endtask
  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_op(a, b, 1'($urandom), $urandom_range(0, 3));
    end
  endtask
  task automatic test_back_to_back(input int m);
    logic [31:0] er [2];
    logic        ez [2];
    int          p, t1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int t = -1; t < 6 * m - 1; t++) begin
      req_a = $urandom;
      req_b = ($urandom_range(0, 3) == 0) ? req_a : $urandom;
      req_op = 1'($urandom);
      for (int d = 0; d < 2; d++)
        if ((t + 1) % (lat[d] + 2) == 0) begin
          er[d] = req_op ? req_a - req_b : req_a + req_b;
          ez[d] = req_a == req_b;
        end
      tick;
      t1 = t + 1;
      for (int d = 0; d < 2; d++) begin
        p = lat[d] + 2;
        n_chk++;
        if ({req_ready[d], rsp_valid[d]} !== {(t1 + 1) % p == 0, t1 % p == lat[d]}) begin
          n_fail++;
          $display("FAIL b2b_handshake d%0d t%0d: req_ready,rsp_valid=%b want %b", d, t1,
                   {req_ready[d], rsp_valid[d]}, {(t1 + 1) % p == 0, t1 % p == lat[d]});
        end
        if (t1 % p == lat[d]) begin
          n_chk++;
          if ({rsp_result[d], rsp_zero[d]} !== {er[d], ez[d]}) begin
            n_fail++;
            $display("FAIL b2b_data d%0d t%0d: got %h/%b want %h/%b", d, t1, rsp_result[d], rsp_zero[d], er[d], ez[d]);
          end
        end
        n_chk++;
        if (op_count[d] !== 16'(cnt[d] + 16'((t1 + 1) / p))) begin
          n_fail++;
          $display("FAIL b2b_count d%0d t%0d: got %h want %h", d, t1, op_count[d], 16'(cnt[d] + 16'((t1 + 1) / p)));
        end
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int d = 0; d < 2; d++) cnt[d] = 16'(cnt[d] + 16'(6 * m / (lat[d] + 2)));
  endtask
  task automatic test_wrap;
    @(negedge clk) force u0.r_op_count = 16'hFFFD;
    @(negedge clk) release u0.r_op_count;
    cnt[0] = 16'hFFFD;
    tick;
    test_back_to_back(2);
    n_chk++;
    if (op_count[0] !== 16'h0001) begin
      n_fail++;
      $display("FAIL op_count_wrap: got %h want 0001", op_count[0]);
    end
  endtask
`ifdef ALU_ISSUE_SELFCHECK_EN
  task automatic test_selfcheck;
    bad_alu = 1'b1;
    req_a = 32'hFFFF_FFFF; req_b = 32'd1; req_op = 1'b0; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (4) tick;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({rsp_valid[d], rsp_result[d], rsp_mismatch[d]} !== {1'b1, 32'd1, 1'b1}) begin
        n_fail++;
        $display("FAIL mismatch_flag d%0d: valid=%b result=%h mismatch=%b want 1/00000001/1", d,
                 rsp_valid[d], rsp_result[d], rsp_mismatch[d]);
      end
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    bad_alu = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cnt[d] = cnt[d] + 16'd1;
      n_chk++;
      if ({rsp_mismatch[d], op_count[d]} !== {1'b0, cnt[d]}) begin
        n_fail++;
        $display("FAIL mismatch_clear d%0d: mismatch=%b count=%h want 0/%h", d, rsp_mismatch[d], op_count[d], cnt[d]);
      end
    end
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_async_reset;
    test_basic;
    test_stall;
    test_overflow;
    test_random;
    test_back_to_back(20);
    test_wrap;
`ifdef ALU_ISSUE_SELFCHECK_EN
    test_selfcheck;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
